// File: rtl/enc_binder_sched.sv
// Sequences the binder packs one at a time: bind, wait for the binder latency,
// then hand the pack index to the bundler over a valid/ready handshake.
module enc_binder_sched #(
  parameter  int NUM_PACKS = 10,
  parameter  int BIND_LAT  = 1,
  localparam int IDX_W     = $clog2(NUM_PACKS)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start_encoding,
  input  logic                 abort,
  output logic                 bind_start,
  output logic [NUM_PACKS-1:0] pack_en,
  output logic [NUM_PACKS-1:0] pack_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_pack_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int LAT_W = (BIND_LAT > 1) ? $clog2(BIND_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    BIND,
    WAIT,
    PRESENT,
    DONE
  } state_t;

  state_t               state, state_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [LAT_W-1:0]     lat_cnt, lat_d;
  logic [NUM_PACKS-1:0] onehot_d;

  // Next-state logic; abort overrides everything, including a pending transfer.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    lat_d   = lat_cnt;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_encoding) begin
            state_d = BIND;
            idx_d   = '0;
          end
        end
        BIND: begin
          state_d = WAIT;
          lat_d   = LAT_W'(BIND_LAT - 1);
        end
        WAIT: begin
          if (lat_cnt == '0) state_d = PRESENT;
          else               lat_d   = lat_cnt - LAT_W'(1);
        end
        PRESENT: begin
          if (out_ready) begin
            if (idx == IDX_W'(NUM_PACKS - 1)) begin
              state_d = DONE;
            end else begin
              state_d = BIND;
              idx_d   = idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
    onehot_d = NUM_PACKS'(1) << idx_d;
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= IDLE;
      idx          <= '0;
      lat_cnt      <= '0;
      bind_start   <= 1'b0;
      pack_en      <= '0;
      pack_sel     <= '0;
      out_valid    <= 1'b0;
      out_pack_idx <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      lat_cnt      <= lat_d;
      bind_start   <= (state_d == BIND);
      pack_en      <= (state_d == BIND) ? onehot_d : '0;
      pack_sel     <= (state_d inside {BIND, WAIT, PRESENT}) ? onehot_d : '0;
      out_valid    <= (state_d == PRESENT);
      out_pack_idx <= (state_d == PRESENT) ? idx_d : '0;
      busy         <= (state_d != IDLE);
      done         <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_enc_binder_sched.sv
// Bench for enc_binder_sched: two instances (10 packs/latency 1 and 3 packs/latency 4)
// share one stimulus stream and are compared every cycle against a pack/time model.
module tb_enc_binder_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst, start_encoding, abort, out_ready;

  logic       a_bind_start, a_out_valid, a_busy, a_done;
  logic [9:0] a_pack_en, a_pack_sel;
  logic [3:0] a_out_pack_idx;

  logic       b_bind_start, b_out_valid, b_busy, b_done;
  logic [2:0] b_pack_en, b_pack_sel;
  logic [1:0] b_out_pack_idx;

  enc_binder_sched #(.NUM_PACKS(10), .BIND_LAT(1)) dutA (
    .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .abort(abort),
    .bind_start(a_bind_start), .pack_en(a_pack_en), .pack_sel(a_pack_sel),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pack_idx(a_out_pack_idx),
    .busy(a_busy), .done(a_done)
  );

  enc_binder_sched #(.NUM_PACKS(3), .BIND_LAT(4)) dutB (
    .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .abort(abort),
    .bind_start(b_bind_start), .pack_en(b_pack_en), .pack_sel(b_pack_sel),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pack_idx(b_out_pack_idx),
    .busy(b_busy), .done(b_done)
  );

  // A run is described by which pack is in flight and how many cycles it has been
  // since that pack's bind; t==0 is the bind cycle, t==lat+1 is presentation.
  typedef struct {
    bit active;
    bit dn;
    int pack;
    int t;
  } mdl_t;

  mdl_t ma, mb;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc, a_done_cyc, b_done_cyc;
  int   xfers, a_dones, stall;
  bit   rdy;

  function automatic mdl_t step(mdl_t m, bit rst_n, bit st, bit ab, bit rd, int nump, int lat);
    mdl_t r = m;
    if (!rst_n || ab) begin
      r.active = 0; r.dn = 0; r.pack = 0; r.t = 0;
    end else if (m.dn) begin
      r.dn = 0;
    end else if (!m.active) begin
      if (st) begin
        r.active = 1; r.pack = 0; r.t = 0;
      end
    end else if (m.t <= lat) begin
      r.t = m.t + 1;
    end else if (rd) begin
      if (m.pack == nump - 1) begin
        r.active = 0; r.dn = 1;
      end else begin
        r.pack = m.pack + 1; r.t = 0;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkInst(input string p, input mdl_t m, input int lat,
                           input logic bs, input logic [31:0] pe, input logic [31:0] ps,
                           input logic ov, input logic [31:0] idx, input logic by,
                           input logic dn);
    logic [31:0] oh;
    logic        ebs, eov;
    oh  = m.active ? (32'd1 << m.pack) : 32'd0;
    ebs = m.active && (m.t == 0);
    eov = m.active && (m.t == lat + 1);
    chk({p, "bind_start"},   32'(bs),  32'(ebs));
    chk({p, "pack_en"},      pe,       ebs ? oh : 32'd0);
    chk({p, "pack_sel"},     ps,       oh);
    chk({p, "out_valid"},    32'(ov),  32'(eov));
    chk({p, "out_pack_idx"}, idx,      eov ? 32'(m.pack) : 32'd0);
    chk({p, "busy"},         32'(by),  32'(m.active || m.dn));
    chk({p, "done"},         32'(dn),  32'(m.dn));
  endtask

  task automatic checkOutput();
    checkInst("a_", ma, 1, a_bind_start, 32'(a_pack_en), 32'(a_pack_sel),
              a_out_valid, 32'(a_out_pack_idx), a_busy, a_done);
    checkInst("b_", mb, 4, b_bind_start, 32'(b_pack_en), 32'(b_pack_sel),
              b_out_valid, 32'(b_out_pack_idx), b_busy, b_done);
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic applyStimulus(input bit rst_n, input bit st, input bit ab, input bit rd);
    nrst           = rst_n;
    start_encoding = st;
    abort          = ab;
    out_ready      = rd;
    if (a_out_valid === 1'b1 && rd && rst_n && !ab) xfers++;
    @(posedge clk);
    cyc++;
    ma = step(ma, rst_n, st, ab, rd, 10, 1);
    mb = step(mb, rst_n, st, ab, rd, 3, 4);
    @(negedge clk);
    checkOutput();
    if (a_done === 1'b1) begin a_done_cyc = cyc; a_dones++; end
    if (b_done === 1'b1) b_done_cyc = cyc;
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    xfers = 0; a_dones = 0;
    a_done_cyc = -1; b_done_cyc = -1;
    nrst = 1'b0; start_encoding = 1'b0; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // Reset, then idle with start low
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    repeat (6) applyStimulus(1, 0, 0, 1'($urandom % 2));

    // Nominal run with out_ready held high
    start_cyc = cyc; a_done_cyc = -1; b_done_cyc = -1;
    applyStimulus(1, 1, 0, 1);
    repeat (34) applyStimulus(1, 0, 0, 1);
    chk("nominal_done_latency", 32'(a_done_cyc - start_cyc), 32'd31);
    chk("lat4_done_latency",    32'(b_done_cyc - start_cyc), 32'd19);

    // Backpressure for 5 cycles while pack 3 is presented
    stall = 0;
    applyStimulus(1, 1, 0, 1);
    for (int i = 0; i < 60; i++) begin
      rdy = 1;
      if (ma.active && ma.pack == 3 && ma.t == 2 && stall < 5) begin
        rdy = 0;
        stall++;
      end
      applyStimulus(1, 0, 0, rdy);
    end
    chk("bp_pack3_presented", 32'(stall), 32'd5);

    // Start pulse mid-run is ignored; random backpressure
    xfers = 0; a_dones = 0;
    applyStimulus(1, 1, 0, 1);
    for (int i = 1; i < 400 && a_busy === 1'b1; i++)
      applyStimulus(1, i == 10, 0, ($urandom % 4) != 0);
    chk("busy_run_finished", 32'(a_busy), 32'd0);
    chk("busy_run_xfers",    32'(xfers),  32'd10);
    chk("busy_run_dones",    32'(a_dones), 32'd1);
    repeat (3) applyStimulus(1, 0, 0, 1);

    // Abort during the wait of pack 5, restart two cycles later
    a_dones = 0;
    applyStimulus(1, 1, 0, 1);
    for (int i = 0; i < 100; i++) begin
      if (ma.active && ma.pack == 5 && ma.t == 1) begin
        applyStimulus(1, 0, 1, 1);
        break;
      end
      applyStimulus(1, 0, 0, 1);
    end
    applyStimulus(1, 0, 0, 1);
    chk("abort_no_done", 32'(a_dones), 32'd0);
    applyStimulus(1, 1, 0, 1);
    repeat (34) applyStimulus(1, 0, 0, 1);
    chk("restart_one_done", 32'(a_dones), 32'd1);

    // Start and abort together while idle
    applyStimulus(1, 1, 1, 1);
    repeat (5) applyStimulus(1, 0, 0, 1);

    // Random traffic including occasional aborts
    repeat (300) applyStimulus(1, ($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 3) != 0);

    // Reset in the middle of a run
    applyStimulus(1, 0, 1, 1);
    applyStimulus(1, 1, 0, 1);
    repeat (6) applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    repeat (4) applyStimulus(1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
